// File: rtl/pipeline_pkg.sv
// Shared pipeline types: branch opcodes, branch-unit FSM states and the
// default program-counter width.
package pipeline_pkg;

  localparam int BUS_COUNTER_DEFAULT = 5;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_BEQ  = 3'd2,
    BR_BNE  = 3'd3,
    BR_BLT  = 3'd4,
    BR_CALL = 3'd5,
    BR_RET  = 3'd6
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } bu_state_t;

endpackage

// File: rtl/return_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest
// entry, so the most recent DEPTH calls are always recoverable.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [PW-1:0]    top_idx;

  // ptr_q is the next free slot, so the top of stack sits one below it.
  assign top_idx  = ptr_q - PW'(1);
  assign pop_data = mem[top_idx];
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) count_d = count_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr_d   = top_idx;
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution and PC redirect with post-branch flush sequencing.
// Define BRANCH_UNIT_RAS_EN to build in the return-address stack for CALL/RET.
module branch_unit
  import pipeline_pkg::*;
#(
  parameter int BUS_COUNTER  = BUS_COUNTER_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   br_valid,
  input  logic [2:0]             br_op,
  input  logic [BUS_COUNTER-1:0] br_target,
  input  logic [BUS_COUNTER-1:0] br_pc,
  input  logic                   flag_z,
  input  logic                   flag_n,
  output logic                   jmp,
  output logic [BUS_COUNTER-1:0] jmp_in,
  output logic                   flush,
  output logic                   busy,
  output logic                   ras_err
);

  bu_state_t              state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [BUS_COUNTER-1:0] tgt_q, tgt_d;
  br_op_t                 op;
  logic                   accept;
  logic                   taken;
  logic [BUS_COUNTER-1:0] target;

  assign op     = br_op_t'(br_op);
  assign accept = br_valid && (state_q == ST_IDLE);

`ifdef BRANCH_UNIT_RAS_EN
  logic                   ras_push, ras_pop, ras_full, ras_empty, err_set;
  logic                   err_q, err_d;
  logic [BUS_COUNTER-1:0] ras_top, ret_addr;

  assign ret_addr = br_pc + BUS_COUNTER'(1);

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (BUS_COUNTER)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ret_addr),
    .pop_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign err_d   = err_q | err_set;
  assign ras_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  logic unused_pc;
  assign unused_pc = ^br_pc;
  assign ras_err   = 1'b0;
`endif

  // Branch decision: only evaluated while idle, so busy cycles never touch the stack.
  always_comb begin
    taken  = 1'b0;
    target = br_target;
`ifdef BRANCH_UNIT_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    if (accept) begin
      case (op)
        BR_JMP: taken = 1'b1;
        BR_BEQ: taken = flag_z;
        BR_BNE: taken = ~flag_z;
        BR_BLT: taken = flag_n;
        BR_CALL: begin
          taken = 1'b1;
`ifdef BRANCH_UNIT_RAS_EN
          ras_push = 1'b1;
          err_set  = ras_full;
`endif
        end
`ifdef BRANCH_UNIT_RAS_EN
        BR_RET: begin
          if (!ras_empty) begin
            taken   = 1'b1;
            ras_pop = 1'b1;
            target  = ras_top;
          end else begin
            err_set = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // cnt_q holds the flush cycles still owed, including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (taken) begin
          state_d = ST_REDIRECT;
          cnt_d   = 3'(FLUSH_CYCLES);
          tgt_d   = target;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_FLUSH;
        if (!stall) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // jmp lives only in REDIRECT, which always lasts exactly one cycle.
  assign jmp    = (state_q == ST_REDIRECT);
  assign flush  = (state_q != ST_IDLE);
  assign busy   = (state_q != ST_IDLE);
  assign jmp_in = tgt_q;

endmodule
